// File: rtl/avalon_arb_pkg.sv
// Shared types for the SDRAM arbiter: FSM state encoding and master ID used to tag in-flight reads.
package avalon_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M0 = 2'd1,
    GNT_M1 = 2'd2
  } arb_state_t;

  typedef logic mid_t;

  localparam mid_t M0_ID = 1'b0;
  localparam mid_t M1_ID = 1'b1;

endpackage

// File: rtl/avalon_sdram_arbiter_id_fifo.sv
// Small synchronous FIFO holding the issuing master of each in-flight read; head is visible combinationally.
// Push is ignored when full and pop is ignored when empty; no pass-through from push to head.
module arb_id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Extra pointer MSB separates the full and empty cases when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/avalon_sdram_arbiter.sv
// Shares one SDRAM Avalon-MM port between M0 (vga reader) and M1 (HPS); 0-cycle command/response routing,
// granted master stalled by s_waitrequest or a full read-ID FIFO. ARB_STATS_EN adds per-master transfer counters.
module avalon_sdram_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16,
  parameter int OUTSTND  = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   s_address,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  output logic                s_read,
  output logic                s_write,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]         stat_m0_cnt,
  output logic [31:0]         stat_m1_cnt,
  output logic                stat_drop
`endif
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [HW-1:0] hold_cnt;
  logic          hold_last;
  logic          m0_req;
  logic          m1_req;
  logic          g_read;
  logic          g_write;
  logic          accept;
  logic          fifo_full;
  logic          fifo_empty;
  logic          rd_pop;
  mid_t          fifo_head;
  mid_t          push_id;

  assign m0_req    = m0_read | m0_write;
  assign m1_req    = m1_read | m1_write;
  assign hold_last = (hold_cnt == HW'(MAX_HOLD - 1));

  always_comb begin
    g_read       = 1'b0;
    g_write      = 1'b0;
    s_address    = '0;
    s_writedata  = '0;
    s_byteenable = '0;
    push_id      = M0_ID;
    case (state)
      GNT_M0: begin
        g_read       = m0_read;
        g_write      = m0_write;
        s_address    = m0_address;
        s_writedata  = m0_writedata;
        s_byteenable = m0_byteenable;
      end
      GNT_M1: begin
        g_read       = m1_read;
        g_write      = m1_write;
        s_address    = m1_address;
        s_writedata  = m1_writedata;
        s_byteenable = m1_byteenable;
        push_id      = M1_ID;
      end
      default: ;
    endcase
  end

  // A read is never forwarded while the ID FIFO is full, so every SDRAM read has a tag slot.
  assign s_read  = g_read & ~fifo_full;
  assign s_write = g_write;
  assign accept  = (g_read | g_write) & ~s_waitrequest & ~(g_read & fifo_full);

  assign m0_waitrequest = ~((state == GNT_M0) & ~s_waitrequest & ~(m0_read & fifo_full));
  assign m1_waitrequest = ~((state == GNT_M1) & ~s_waitrequest & ~(m1_read & fifo_full));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_req)      state_nxt = GNT_M0;
        else if (m1_req) state_nxt = GNT_M1;
      end
      GNT_M0: begin
        if (!m0_req)                              state_nxt = m1_req ? GNT_M1 : IDLE;
        else if (accept && hold_last && m1_req)   state_nxt = GNT_M1;
      end
      GNT_M1: begin
        if (!m1_req)                              state_nxt = m0_req ? GNT_M0 : IDLE;
        else if (accept && hold_last && m0_req)   state_nxt = GNT_M0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)        hold_cnt <= '0;
      else if (accept && !hold_last) hold_cnt <= hold_cnt + 1'b1;
    end
  end

  arb_id_fifo #(
    .WIDTH (1),
    .DEPTH (OUTSTND)
  ) u_id_fifo (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .push     (accept & g_read),
    .push_dat (push_id),
    .pop      (rd_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  // Responses with no tag outstanding (e.g. after a reset mid-burst) are discarded.
  assign rd_pop           = s_readdatavalid & ~fifo_empty;
  assign m0_readdatavalid = rd_pop & (fifo_head == M0_ID);
  assign m1_readdatavalid = rd_pop & (fifo_head == M1_ID);
  assign m0_readdata      = m0_readdatavalid ? s_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? s_readdata : '0;

`ifdef ARB_STATS_EN
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      stat_m0_cnt <= '0;
      stat_m1_cnt <= '0;
      stat_drop   <= 1'b0;
    end else begin
      if (accept && state == GNT_M0) stat_m0_cnt <= stat_m0_cnt + 32'd1;
      if (accept && state == GNT_M1) stat_m1_cnt <= stat_m1_cnt + 32'd1;
      if (s_readdatavalid && fifo_empty) stat_drop <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_avalon_sdram_arbiter.sv
// Directed bench for avalon_sdram_arbiter: SDRAM read responder, transfer monitor, one task per scenario.
module tb_avalon_sdram_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic [3:0]  s_byteenable;
  logic        s_read, s_write, s_waitrequest, s_readdatavalid;
`ifdef ARB_STATS_EN
  logic [31:0] stat_m0_cnt, stat_m1_cnt;
  logic        stat_drop;
`endif

  logic        resp_vld, resp_en, man_vld;
  logic [31:0] resp_dat, man_dat;
  int          resp_lat, cyc;
  int          due_q[$];
  logic [31:0] dat_q[$];

  logic [31:0] m0_rx[$], m1_rx[$], wr_a[$], wr_d[$];
  logic [3:0]  wr_be[$];
  int          acc_q[$];
  int          sread_cnt;
  bit          rd_leak;

  int n_cmp = 0;
  int n_err = 0;

  assign s_readdatavalid = resp_vld | man_vld;
  assign s_readdata      = resp_vld ? resp_dat : man_dat;

  avalon_sdram_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_HOLD(16), .OUTSTND(8)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_read(s_read), .s_write(s_write), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid)
`ifdef ARB_STATS_EN
    , .stat_m0_cnt(stat_m0_cnt), .stat_m1_cnt(stat_m1_cnt), .stat_drop(stat_drop)
`endif
  );

  initial forever #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] resp_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // SDRAM model: fixed-latency, in-order read responses.
  initial begin
    resp_vld = 1'b0;
    resp_dat = '0;
    cyc      = 0;
    forever begin
      @(negedge sys_clk);
      if (resp_en && s_read && !s_waitrequest) begin
        due_q.push_back(cyc + resp_lat);
        dat_q.push_back(resp_of(s_address));
      end
      @(posedge sys_clk); #1;
      cyc++;
      resp_vld = 1'b0;
      if (resp_en && due_q.size() > 0 && due_q[0] == cyc) begin
        resp_vld = 1'b1;
        resp_dat = dat_q.pop_front();
        void'(due_q.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge sys_clk);
    if (m0_readdatavalid) m0_rx.push_back(m0_readdata);
    if (m1_readdatavalid) m1_rx.push_back(m1_readdata);
    if ((!m0_readdatavalid && m0_readdata != 0) || (!m1_readdatavalid && m1_readdata != 0)) rd_leak = 1'b1;
    if (!m0_waitrequest && (m0_read || m0_write)) acc_q.push_back(0);
    if (!m1_waitrequest && (m1_read || m1_write)) acc_q.push_back(1);
    if (s_read && !s_waitrequest) sread_cnt++;
    if (s_write && !s_waitrequest) begin
      wr_a.push_back(s_address);
      wr_d.push_back(s_writedata);
      wr_be.push_back(s_byteenable);
    end
  end

  task automatic set_cmd(input int m, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    end
  endtask

  task automatic xfer(input int m, input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    bit done;
    n = 0;
    done = 0;
    set_cmd(m, !wr, wr, a, d, be);
    while (!done && n < 100) begin
      @(negedge sys_clk);
      done = (m == 0) ? !m0_waitrequest : !m1_waitrequest;
      @(posedge sys_clk); #1;
      n++;
    end
    set_cmd(m, 1'b0, 1'b0, '0, '0, '0);
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL xfer_timeout m%0d addr %h: waitrequest=1 for %0d cycles, required accept", m, a, n);
    end
  endtask

  task automatic test_reset;
    sys_rst = 1'b1;
    s_waitrequest = 1'b0;
    resp_en = 1'b0; resp_lat = 3; man_vld = 1'b0; man_dat = '0;
    rd_leak = 1'b0; sread_cnt = 0;
    set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
    set_cmd(1, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(posedge sys_clk);
    #1;
    n_cmp++;
    if ({m0_waitrequest, m1_waitrequest, s_read, s_write, m0_readdatavalid, m1_readdatavalid} !== 6'b110000) begin
      n_err++;
      $display("FAIL reset_ctl: got %b, required 110000",
               {m0_waitrequest, m1_waitrequest, s_read, s_write, m0_readdatavalid, m1_readdatavalid});
    end
    n_cmp++;
    if (m0_readdata !== 32'h0 || m1_readdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_readdata: got %h/%h, required 0/0", m0_readdata, m1_readdata);
    end
    n_cmp++;
    if (s_address !== 32'h0) begin
      n_err++;
      $display("FAIL reset_s_address: got %h, required 0", s_address);
    end
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
  endtask

  task automatic test_m0_reads;
    m0_rx.delete(); m1_rx.delete(); sread_cnt = 0;
    resp_lat = 3; resp_en = 1'b1;
    for (int i = 0; i < 4; i++) xfer(0, 1'b0, 32'h100 + 32'(4 * i), '0, 4'hf);
    repeat (8) @(posedge sys_clk);
    #1;
    resp_en = 1'b0;
    n_cmp++;
    if (sread_cnt !== 4) begin
      n_err++;
      $display("FAIL t1_sread_count: got %0d, required 4", sread_cnt);
    end
    n_cmp++;
    if (m0_rx.size() !== 4 || m1_rx.size() !== 0) begin
      n_err++;
      $display("FAIL t1_rdv_count: m0 got %0d m1 got %0d, required 4/0", m0_rx.size(), m1_rx.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (m0_rx[i] !== resp_of(32'h100 + 32'(4 * i))) begin
          n_err++;
          $display("FAIL t1_rdata%0d: got %h, required %h", i, m0_rx[i], resp_of(32'h100 + 32'(4 * i)));
        end
      end
    end
  endtask

  task automatic test_hold;
    int bad;
    acc_q.delete();
    fork
      for (int i = 0; i < 20; i++) xfer(0, 1'b1, 32'h1000 + 32'(4 * i), 32'(i), 4'hf);
      for (int j = 0; j < 4; j++)  xfer(1, 1'b1, 32'h1800 + 32'(4 * j), 32'(j), 4'hf);
    join
    repeat (3) @(posedge sys_clk);
    #1;
    n_cmp++;
    if (acc_q.size() !== 24) begin
      n_err++;
      $display("FAIL t2_accept_count: got %0d, required 24", acc_q.size());
    end else begin
      bad = -1;
      for (int i = 0; i < 24; i++)
        if (bad < 0 && acc_q[i] != ((i >= 16 && i < 20) ? 1 : 0)) bad = i;
      n_cmp++;
      if (bad >= 0) begin
        n_err++;
        $display("FAIL t2_grant_order: transfer %0d from m%0d, required m%0d", bad, acc_q[bad],
                 (bad >= 16 && bad < 20) ? 1 : 0);
      end
    end
  endtask

  task automatic test_mixed;
    logic [3:0] be_tab [4];
    be_tab = '{4'h1, 4'h3, 4'hc, 4'hf};
    m0_rx.delete(); m1_rx.delete(); wr_a.delete(); wr_d.delete(); wr_be.delete();
    resp_lat = 5; resp_en = 1'b1;
    fork
      for (int i = 0; i < 4; i++) begin
        xfer(0, 1'b0, 32'h2000 + 32'(4 * i), '0, 4'hf);
        @(posedge sys_clk); #1;
      end
      for (int j = 0; j < 4; j++) xfer(1, 1'b1, 32'h3000 + 32'(8 * j), 32'hC0DE_0000 + 32'(j), be_tab[j]);
    join
    repeat (10) @(posedge sys_clk);
    #1;
    resp_en = 1'b0;
    n_cmp++;
    if (m0_rx.size() !== 4 || m1_rx.size() !== 0) begin
      n_err++;
      $display("FAIL t3_rdv_count: m0 got %0d m1 got %0d, required 4/0", m0_rx.size(), m1_rx.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (m0_rx[i] !== resp_of(32'h2000 + 32'(4 * i))) begin
          n_err++;
          $display("FAIL t3_rdata%0d: got %h, required %h", i, m0_rx[i], resp_of(32'h2000 + 32'(4 * i)));
        end
      end
    end
    n_cmp++;
    if (wr_a.size() !== 4) begin
      n_err++;
      $display("FAIL t3_write_count: got %0d, required 4", wr_a.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        n_cmp++;
        if (wr_a[j] !== 32'h3000 + 32'(8 * j) || wr_d[j] !== 32'hC0DE_0000 + 32'(j) || wr_be[j] !== be_tab[j]) begin
          n_err++;
          $display("FAIL t3_write%0d: got %h/%h/%h, required %h/%h/%h", j, wr_a[j], wr_d[j], wr_be[j],
                   32'h3000 + 32'(8 * j), 32'hC0DE_0000 + 32'(j), be_tab[j]);
        end
      end
    end
  endtask

  task automatic test_fifo_full;
    bit bad;
    for (int i = 0; i < 8; i++) xfer(0, 1'b0, 32'h4000 + 32'(4 * i), '0, 4'hf);
    set_cmd(0, 1'b1, 1'b0, 32'h4020, '0, 4'hf);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      if (m0_waitrequest !== 1'b1 || s_read !== 1'b0) bad = 1;
      @(posedge sys_clk); #1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL t4_full_stall: 9th read not held off (waitrequest=%b s_read=%b), required 1/0", m0_waitrequest, s_read);
    end
    man_vld = 1'b1; man_dat = 32'h5100_0000;
    @(negedge sys_clk);
    n_cmp++;
    if (m0_waitrequest !== 1'b1 || m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h5100_0000) begin
      n_err++;
      $display("FAIL t4_pop_cycle: wr=%b rdv=%b data=%h, required 1/1/51000000", m0_waitrequest, m0_readdatavalid, m0_readdata);
    end
    @(posedge sys_clk); #1;
    man_vld = 1'b0;
    @(negedge sys_clk);
    n_cmp++;
    if (m0_waitrequest !== 1'b0 || s_read !== 1'b1 || s_address !== 32'h4020) begin
      n_err++;
      $display("FAIL t4_accept_after_pop: wr=%b s_read=%b addr=%h, required 0/1/4020", m0_waitrequest, s_read, s_address);
    end
    @(posedge sys_clk); #1;
    set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 8; i++) begin
      man_vld = 1'b1; man_dat = 32'h5100_0001 + 32'(i);
      @(negedge sys_clk);
      n_cmp++;
      if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h5100_0001 + 32'(i) || m1_readdatavalid !== 1'b0) begin
        n_err++;
        $display("FAIL t4_drain%0d: rdv=%b/%b data=%h, required 1/0 %h", i, m0_readdatavalid, m1_readdatavalid,
                 m0_readdata, 32'h5100_0001 + 32'(i));
      end
      @(posedge sys_clk); #1;
    end
    man_dat = 32'h5100_00FF;
    @(negedge sys_clk);
    n_cmp++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      n_err++;
      $display("FAIL t4_empty_drop: rdv=%b/%b, required 0/0", m0_readdatavalid, m1_readdatavalid);
    end
    @(posedge sys_clk); #1;
    man_vld = 1'b0;
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats;
    n_cmp++;
    if (stat_m0_cnt !== 32'd37 || stat_m1_cnt !== 32'd8 || stat_drop !== 1'b1) begin
      n_err++;
      $display("FAIL stats_counts: got %0d/%0d/%b, required 37/8/1", stat_m0_cnt, stat_m1_cnt, stat_drop);
    end
  endtask
`endif

  task automatic test_reset_inflight;
    for (int i = 0; i < 3; i++) xfer(1, 1'b0, 32'h5000 + 32'(4 * i), '0, 4'hf);
    sys_rst = 1'b1;
    #1;
    n_cmp++;
    if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 || s_read !== 1'b0) begin
      n_err++;
      $display("FAIL t5_async_reset: wr=%b/%b s_read=%b, required 1/1/0", m0_waitrequest, m1_waitrequest, s_read);
    end
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    m0_rx.delete(); m1_rx.delete();
    for (int i = 0; i < 3; i++) begin
      man_vld = 1'b1; man_dat = 32'h6600_0000 + 32'(i);
      @(posedge sys_clk); #1;
      man_vld = 1'b0;
      @(posedge sys_clk); #1;
    end
    n_cmp++;
    if (m0_rx.size() !== 0 || m1_rx.size() !== 0) begin
      n_err++;
      $display("FAIL t5_lost_reads: rdv seen m0=%0d m1=%0d, required 0/0", m0_rx.size(), m1_rx.size());
    end
`ifdef ARB_STATS_EN
    n_cmp++;
    if (stat_drop !== 1'b1 || stat_m1_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL t5_stat_drop: drop=%b m1_cnt=%0d, required 1/0", stat_drop, stat_m1_cnt);
    end
`endif
    n_cmp++;
    if (rd_leak !== 1'b0) begin
      n_err++;
      $display("FAIL readdata_leak: nonzero readdata without readdatavalid, required none");
    end
  endtask

  task automatic test_stall;
    bit bad;
    s_waitrequest = 1'b1;
    set_cmd(1, 1'b0, 1'b1, 32'h6000, 32'hFACE_0006, 4'h5);
    @(posedge sys_clk); #1;
    set_cmd(0, 1'b0, 1'b1, 32'h7000, 32'hBEEF_0007, 4'hf);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      if (s_write !== 1'b1 || s_address !== 32'h6000 || s_writedata !== 32'hFACE_0006 || s_byteenable !== 4'h5 ||
          m1_waitrequest !== 1'b1 || m0_waitrequest !== 1'b1) bad = 1;
      @(posedge sys_clk); #1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL t6_stall_stable: s_addr=%h wr=%b/%b, required 6000 held with both stalled", s_address,
               m0_waitrequest, m1_waitrequest);
    end
    s_waitrequest = 1'b0;
    @(negedge sys_clk);
    n_cmp++;
    if (m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b1 || s_address !== 32'h6000) begin
      n_err++;
      $display("FAIL t6_release: wr=%b/%b addr=%h, required 1/0 6000", m0_waitrequest, m1_waitrequest, s_address);
    end
    @(posedge sys_clk); #1;
    set_cmd(1, 1'b0, 1'b0, '0, '0, '0);
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    n_cmp++;
    if (m0_waitrequest !== 1'b0 || s_address !== 32'h7000 || s_writedata !== 32'hBEEF_0007) begin
      n_err++;
      $display("FAIL t6_handover: wr=%b addr=%h data=%h, required 0 7000 beef0007", m0_waitrequest, s_address, s_writedata);
    end
    @(posedge sys_clk); #1;
    set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_m0_reads();
    test_hold();
    test_mixed();
    test_fifo_full();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    test_reset_inflight();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
